// File: rtl/timer_pkg.sv
// Shared definitions for the clock/timer push-button front end.
//
// Contents:
//   key_state_e          - per-key press state (IDLE, PRESSED, HELD)
//   KEY_DEBOUNCE_CYCLES  - default debounce window (20 ms at 50 MHz)
//   KEY_LONG_CYCLES      - default long-press threshold (1 s at 50 MHz)
//   KEY_REPEAT_CYCLES    - default auto-repeat period (200 ms at 50 MHz)
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } key_state_e;

  localparam int KEY_DEBOUNCE_CYCLES = 1_000_000;
  localparam int KEY_LONG_CYCLES     = 50_000_000;
  localparam int KEY_REPEAT_CYCLES   = 10_000_000;

endpackage

// File: rtl/key_channel.sv
// Conditioning for a single push-button: 2-FF synchronizer, debouncer and
// press/hold FSM that turns the debounced level into single-cycle events.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous reset, active low
//   key_n        in   raw key, 0 = pressed, asynchronous to clk
//   key_level    out  debounced level, 1 = pressed
//   press        out  1-cycle pulse on accepted press
//   key_release  out  1-cycle pulse on accepted release
//   short_press  out  1-cycle pulse on release of a hold shorter than LONG_CYCLES
//   long_press   out  1-cycle pulse once per hold after LONG_CYCLES
//   key_repeat   out  1-cycle pulse every REPEAT_CYCLES after long_press
//
// The release/repeat events are called key_release/key_repeat because
// "release" and "repeat" are reserved words in SystemVerilog.
module key_channel
  import timer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = KEY_LONG_CYCLES,
  parameter int REPEAT_CYCLES   = KEY_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_level,
  output logic press,
  output logic key_release,
  output logic short_press,
  output logic long_press,
  output logic key_repeat
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  logic              sync1, sync2;
  logic [DB_W-1:0]   db_cnt;
  logic              mismatch;
  key_state_e        state, state_d;
  logic [HOLD_W-1:0] hold_cnt, hold_d;
  logic [REP_W-1:0]  rep_cnt, rep_d;
  logic press_d, release_d, short_d, long_d, repeat_d;

  // Synchronizer resets to 1 so a key held through reset looks released
  // and has to be debounced again before it can produce a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // Synced key is active low, debounced level is active high.
  assign mismatch = (~sync2) != key_level;

  // The level only flips after DEBOUNCE_CYCLES consecutive mismatching
  // cycles; any agreeing cycle restarts the count, so short bounces vanish.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_level <= 1'b0;
      db_cnt    <= '0;
    end else if (!mismatch) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      key_level <= ~key_level;
      db_cnt    <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // State register; event pulses are registered here too so each one
  // appears the cycle after its causing transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      rep_cnt     <= '0;
      press       <= 1'b0;
      key_release <= 1'b0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
      key_repeat  <= 1'b0;
    end else begin
      state       <= state_d;
      hold_cnt    <= hold_d;
      rep_cnt     <= rep_d;
      press       <= press_d;
      key_release <= release_d;
      short_press <= short_d;
      long_press  <= long_d;
      key_repeat  <= repeat_d;
    end
  end

  // Next state and counters. hold_cnt stops once HELD is reached, so it
  // never needs to count past LONG_CYCLES-1.
  always_comb begin
    state_d = state;
    hold_d  = hold_cnt;
    rep_d   = rep_cnt;
    case (state)
      IDLE: begin
        if (key_level) begin
          state_d = PRESSED;
          hold_d  = '0;
        end
      end
      PRESSED: begin
        if (!key_level) begin
          state_d = IDLE;
        end else if (hold_cnt == HOLD_LAST) begin
          state_d = HELD;
          rep_d   = '0;
        end else begin
          hold_d = hold_cnt + 1'b1;
        end
      end
      HELD: begin
        if (!key_level) begin
          state_d = IDLE;
        end else if (rep_cnt == REP_LAST) begin
          rep_d = '0;
        end else begin
          rep_d = rep_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Event decode. Release wins over a coincident long_press or repeat
  // because those are only raised while the level is still pressed.
  always_comb begin
    press_d   = (state == IDLE) && key_level;
    release_d = (state != IDLE) && !key_level;
    short_d   = (state == PRESSED) && !key_level;
    long_d    = (state == PRESSED) && key_level && (hold_cnt == HOLD_LAST);
    repeat_d  = (state == HELD) && key_level && (rep_cnt == REP_LAST);
  end

endmodule

// File: rtl/key_conditioner.sv
// Front end for the pause/program/set push-buttons. Each raw, bouncing,
// active-low key is conditioned independently into a debounced level and
// clk-synchronous single-cycle events for the timekeeping/display block.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous reset, active low
//   key_n        in   [NUM_KEYS] raw keys, 0 = pressed
//   key_level    out  [NUM_KEYS] debounced level, 1 = pressed
//   press        out  [NUM_KEYS] press pulse
//   key_release  out  [NUM_KEYS] release pulse
//   short_press  out  [NUM_KEYS] short-press pulse (on release)
//   long_press   out  [NUM_KEYS] long-press pulse
//   key_repeat   out  [NUM_KEYS] auto-repeat pulse after long press
module key_conditioner
  import timer_pkg::*;
#(
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = KEY_LONG_CYCLES,
  parameter int REPEAT_CYCLES   = KEY_REPEAT_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] short_press,
  output logic [NUM_KEYS-1:0] long_press,
  output logic [NUM_KEYS-1:0] key_repeat
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_channel (
      .clk        (clk),
      .rst        (rst),
      .key_n      (key_n[i]),
      .key_level  (key_level[i]),
      .press      (press[i]),
      .key_release(key_release[i]),
      .short_press(short_press[i]),
      .long_press (long_press[i]),
      .key_repeat (key_repeat[i])
    );
  end

endmodule
